// File: rtl/fbw_sink.sv
// Frame-buffer write sink: double-banked line buffer, row copy into frame memory, frame swap arbitration.
// Optional drop statistics enabled by defining FBW_SINK_STATS_EN.
module fbw_sink #(
    parameter int N_ROWS     = 64,
    parameter int N_COLS     = 64,
    parameter int BITDEPTH   = 24,
    parameter int LOG_N_ROWS = $clog2(N_ROWS),
    parameter int LOG_N_COLS = $clog2(N_COLS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [LOG_N_ROWS-1:0]            fbw_row_addr,
    input  logic                             fbw_row_store,
    output logic                             fbw_row_rdy,
    input  logic                             fbw_row_swap,
    input  logic [BITDEPTH-1:0]              fbw_data,
    input  logic [LOG_N_COLS-1:0]            fbw_col_addr,
    input  logic                             fbw_wren,
    input  logic                             frame_swap,
    output logic                             frame_rdy,
    output logic [LOG_N_ROWS+LOG_N_COLS:0]   fm_addr,
    output logic [BITDEPTH-1:0]              fm_data,
    output logic                             fm_valid,
    input  logic                             fm_ready,
    output logic                             disp_swap_req,
    input  logic                             disp_swap_ack,
    output logic                             disp_frame
`ifdef FBW_SINK_STATS_EN
    ,
    input  logic                             stat_clr,
    output logic [7:0]                       stat_drops
`endif
);

    localparam logic [LOG_N_COLS-1:0] LAST_COL = LOG_N_COLS'(N_COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PUSH
    } state_t;

    state_t state, state_nx;

    logic [BITDEPTH-1:0]   lbuf [2*N_COLS];
    logic                  wb;
    logic                  cp_bank;
    logic [LOG_N_ROWS-1:0] cp_row;
    logic [LOG_N_COLS-1:0] cp_col;
    logic                  wr_frame;
    logic                  swap_pending;
    logic                  row_acc;
    logic                  swap_acc;
    logic                  beat_done;
    logic                  last_col;

    assign fbw_row_rdy = (state == S_IDLE) && !swap_pending;
    assign frame_rdy   = !swap_pending;
    assign row_acc     = fbw_row_store && fbw_row_rdy;
    assign swap_acc    = frame_swap && frame_rdy;
    assign last_col    = (cp_col == LAST_COL);
    assign beat_done   = fm_valid && fm_ready;
    assign fm_addr     = {wr_frame, cp_row, cp_col};
    assign disp_frame  = ~wr_frame;

    // Producer writes are never blocked; contents need no reset.
    always_ff @(posedge clk) begin
        if (fbw_wren)
            lbuf[{wb, fbw_col_addr}] <= fbw_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        fm_valid = 1'b0;
        case (state)
            S_IDLE:  if (row_acc) state_nx = S_FETCH;
            S_FETCH: state_nx = S_PUSH;
            S_PUSH: begin
                fm_valid = 1'b1;
                if (fm_ready)
                    state_nx = last_col ? S_IDLE : S_FETCH;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb            <= 1'b0;
            cp_bank       <= 1'b0;
            cp_row        <= '0;
            cp_col        <= '0;
            fm_data       <= '0;
            wr_frame      <= 1'b0;
            swap_pending  <= 1'b0;
            disp_swap_req <= 1'b0;
        end else begin
            if (row_acc) begin
                cp_row  <= fbw_row_addr;
                cp_bank <= wb;
                cp_col  <= '0;
                if (fbw_row_swap)
                    wb <= ~wb;
            end else if (beat_done && !last_col) begin
                cp_col <= cp_col + LOG_N_COLS'(1);
            end

            // fm_data only changes in FETCH, so it stays stable across PUSH stalls.
            if (state == S_FETCH)
                fm_data <= lbuf[{cp_bank, cp_col}];

            if (swap_acc)
                swap_pending <= 1'b1;

            // A pending swap waits for any in-flight copy so it lands in the old frame.
            if (disp_swap_req && disp_swap_ack) begin
                wr_frame      <= ~wr_frame;
                disp_swap_req <= 1'b0;
                swap_pending  <= 1'b0;
            end else if (swap_pending && state == S_IDLE) begin
                disp_swap_req <= 1'b1;
            end
        end
    end

`ifdef FBW_SINK_STATS_EN
    logic drop;
    assign drop = (fbw_row_store && !fbw_row_rdy) || (frame_swap && !frame_rdy);

    always_ff @(posedge clk) begin
        if (rst || stat_clr)
            stat_drops <= '0;
        else if (drop && stat_drops != 8'hFF)
            stat_drops <= stat_drops + 8'd1;
    end
`endif

endmodule

// File: doc/fbw_sink.md
Name: fbw_sink

Overview:
- Receiving end of the frame-buffer write interface that pattern generators and other producers drive.
- Holds a double-banked line buffer that accepts per-pixel writes from the producer.
- On a row store, copies the finished line into the frame memory through a valid/ready write stream.
- Arbitrates frame swaps between the producer and the display scan side so that the producer never writes into the frame being displayed.

Parameters:
- N_ROWS, 64: number of rows; must be a power of 2.
- N_COLS, 64: number of columns; must be a power of 2.
- BITDEPTH, 24: pixel width in bits.
- LOG_N_ROWS, $clog2(N_ROWS): auto-set.
- LOG_N_COLS, $clog2(N_COLS): auto-set.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- fbw_row_addr  in  LOG_N_ROWS  row targeted by the store.
- fbw_row_store  in  1  request to copy the current line bank to row fbw_row_addr.
- fbw_row_rdy  out  1  sink can accept a row store.
- fbw_row_swap  in  1  toggle the write bank together with the store.
- fbw_data  in  BITDEPTH  pixel data.
- fbw_col_addr  in  LOG_N_COLS  pixel column.
- fbw_wren  in  1  pixel write strobe.
- frame_swap  in  1  producer has finished a frame.
- frame_rdy  out  1  producer may start a new frame.
- fm_addr  out  1+LOG_N_ROWS+LOG_N_COLS  frame memory address {wr_frame, row, col}.
- fm_data  out  BITDEPTH  frame memory write data.
- fm_valid  out  1  write beat valid.
- fm_ready  in  1  frame memory accepts the beat.
- disp_swap_req  out  1  level request to the display to swap frames.
- disp_swap_ack  in  1  one-cycle pulse from the display, issued at vblank.
- disp_frame  out  1  frame index the display reads; always ~wr_frame.

Behaviour:
- Reset values: fbw_row_rdy=1, frame_rdy=1, fm_valid=0, fm_addr=0, fm_data=0, disp_swap_req=0, wr_frame=0 (so disp_frame=1), write bank wb=0.
- A reset asserted mid-copy or mid-swap aborts the operation and restores all of the reset values above. Line buffer contents are don't-care after reset.
- Line buffer: 2 x N_COLS x BITDEPTH. fbw_wren writes fbw_data to {wb, fbw_col_addr} at the clock edge, at any time and regardless of fbw_row_rdy.
- Row store is accepted when fbw_row_store && fbw_row_rdy. On acceptance:
  - Latch fbw_row_addr into cp_row and wb into cp_bank.
  - If fbw_row_swap is also high, wb toggles on the same edge.
  - fbw_row_rdy drops on the next cycle.
- fbw_row_store while fbw_row_rdy=0 is ignored and produces no state change.
- Copy FSM:
  - IDLE: on acceptance, go to FETCH with cp_col=0.
  - FETCH: one cycle to read the line buffer at {cp_bank, cp_col} (registered read, latency 1); go to PUSH.
  - PUSH: fm_valid=1 with fm_addr={wr_frame, cp_row, cp_col} and fm_data held stable until fm_ready. On fm_valid && fm_ready:
    - if cp_col == N_COLS-1, go to IDLE;
    - otherwise increment cp_col and go to FETCH.
  - Throughput is 1 pixel per 2 cycles at best. Copying a full row takes 2*N_COLS cycles plus the stall cycles.
- fbw_row_rdy = (FSM==IDLE) && !swap_pending.
- Frame swap is accepted when frame_swap && frame_rdy. On acceptance, swap_pending is set and frame_rdy and fbw_row_rdy drop on the next cycle.
  - frame_swap while frame_rdy=0 is ignored.
- A frame swap and a row store accepted in the same cycle are both taken. The copy completes first, with the current wr_frame.
- Swap sequencing:
  - Once swap_pending && FSM==IDLE, disp_swap_req rises and holds.
  - On disp_swap_ack: wr_frame toggles, disp_swap_req and swap_pending clear, and frame_rdy and fbw_row_rdy return to 1 on the next cycle.
  - disp_swap_ack while disp_swap_req=0 is ignored.
- Counter wrap: cp_col wraps only through the IDLE reload; the row address is taken only from the latch.

Optional Feature:
- Macro: FBW_SINK_STATS_EN.
- Defined:
  - Adds output stat_drops, 8 bits, reset 0.
  - Increments by 1 per cycle where (fbw_row_store && !fbw_row_rdy) || (frame_swap && !frame_rdy).
  - Saturates at 8'hFF.
  - Adds input stat_clr, 1 bit; when high, zeroes the counter, taking priority over an increment in the same cycle.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- N_COLS=64, fm_ready=1. Write col c with data c, then row_store+swap at row 5 -> 64 beats; beat k has fm_addr={0,5,k}, fm_data=k. fbw_row_rdy=0 for 128 cycles, then back to 1. wb=1.
- fm_ready toggled randomly during the copy -> fm_addr and fm_data stay stable while fm_valid && !fm_ready. No beat is lost or duplicated; exactly 64 handshakes.
- frame_swap and row_store in the same cycle -> copy completes at wr_frame=0, then disp_swap_req=1. Ack pulse -> disp_frame=0, wr_frame=1, frame_rdy=1 one cycle after the ack.
- row_store while a copy is busy, and frame_swap while a swap is pending -> both ignored, with no extra beats. With FBW_SINK_STATS_EN, stat_drops=2. Then 300 drops give stat_drops=0xFF, and stat_clr gives 0.
- rst asserted at beat 20 of a copy -> the next cycle shows fm_valid=0, fbw_row_rdy=1, frame_rdy=1, disp_swap_req=0, disp_frame=1. A subsequent store performs a clean 64-beat copy.
